cgra_kernel_scheduler: RTL

- Queues kernel-launch requests written by the host through the CGRA peripheral registers.
- Dispatches each request to the CGRA controller's accelerator-request handshake (acc_req/ker_id/acc_ack) once its target columns and event slot are free.
- Tracks per-column busy state from the controller's acc_end, and pulses a per-slot completion event when all columns of a launch have finished.
- Sits between the peripheral register front-end and cgra_controller. It removes the need for host software to poll column state before issuing back-to-back kernels.

---
 rtl/cgra_pkg.sv | 17 +
 rtl/cgra_sched_fifo.sv | 68 ++++++
 rtl/cgra_kernel_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cgra_pkg.sv
// Shared CGRA types for the kernel launch scheduler.
// Holds the launch-queue entry layout and default sizing.
package cgra_pkg;

    localparam int SCHED_N_COL       = 4;
    localparam int SCHED_N_SLOTS     = 2;
    localparam int SCHED_KER_ID_W    = 4;
    localparam int SCHED_QUEUE_DEPTH = 4;
    localparam int SCHED_SLOT_W      = $clog2(SCHED_N_SLOTS);

    typedef struct packed {
        logic [SCHED_KER_ID_W-1:0] ker_id;
        logic [SCHED_N_COL-1:0]    col_mask;
        logic [SCHED_SLOT_W-1:0]   slot;
    } sched_entry_t;

endpackage

// File: rtl/cgra_sched_fifo.sv
// Circular FIFO of launch entries with flush.
// keep_head_i preserves the head entry across a flush.
module cgra_sched_fifo
    import cgra_pkg::*;
#(
    parameter int DEPTH = SCHED_QUEUE_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  sched_entry_t           data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic                   keep_head_i,
    output sched_entry_t           data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PW = $clog2(DEPTH);

    sched_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q, rd_n, wr_base, wr_n;
    logic [PW:0]   cnt_q, cnt_base, cnt_n;
    logic          do_push, do_pop, keep;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    // Next pointers and level; a flush rebases the write side on the read side.
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && !full_o;
        keep    = keep_head_i && !empty_o && !do_pop;
        rd_n    = rd_q + PW'(do_pop);
        if (flush_i) begin
            cnt_base = (PW+1)'(keep);
            wr_base  = rd_n + PW'(keep);
        end else begin
            cnt_base = cnt_q - (PW+1)'(do_pop);
            wr_base  = wr_q;
        end
        cnt_n = cnt_base + (PW+1)'(do_push);
        wr_n  = wr_base + PW'(do_push);
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_n;
            wr_q  <= wr_n;
            cnt_q <= cnt_n;
        end
    end

    // Entry storage, written at the rebased write pointer.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_base] <= data_i;
    end

endmodule

// File: rtl/cgra_kernel_scheduler.sv
// Queues kernel launches and dispatches them to the CGRA controller.
// Optional head-stall counter enabled by defining CGRA_SCHED_PERF_EN.
module cgra_kernel_scheduler
    import cgra_pkg::*;
#(
    parameter int N_COL       = SCHED_N_COL,
    parameter int N_SLOTS     = SCHED_N_SLOTS,
    parameter int KER_ID_W    = SCHED_KER_ID_W,
    parameter int QUEUE_DEPTH = SCHED_QUEUE_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_valid_i,
    output logic                         push_ready_o,
    input  logic [KER_ID_W-1:0]          push_ker_id_i,
    input  logic [N_COL-1:0]             push_col_mask_i,
    input  logic [$clog2(N_SLOTS)-1:0]   push_slot_i,
    input  logic                         flush_i,
    output logic [N_COL-1:0]             acc_req_o,
    output logic [KER_ID_W-1:0]          ker_id_req_o,
    input  logic                         acc_ack_i,
    input  logic [N_COL-1:0]             acc_end_i,
    output logic [N_COL-1:0]             col_busy_o,
    output logic [$clog2(QUEUE_DEPTH):0] queue_level_o,
    output logic [N_SLOTS-1:0]           evt_o,
    output logic [31:0]                  stall_cnt_o
);

    localparam int SW = $clog2(N_SLOTS);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [0:0]          state_q;
    logic [N_COL-1:0]    busy_q, busy_n, req_q;
    logic [KER_ID_W-1:0] ker_q;
    logic [SW-1:0]       slot_q;
    logic [N_COL-1:0]    pend_q [N_SLOTS];
    logic [N_COL-1:0]    pend_n [N_SLOTS];
    logic [N_SLOTS-1:0]  evt_q, evt_n;
    sched_entry_t        push_ent, head;
    logic                full, empty, blocked, idle_head;
    logic                zero_pop, go_req, ack_pop, stall_ev;

    assign push_ent = '{ker_id: push_ker_id_i, col_mask: push_col_mask_i,
                        slot: push_slot_i};

    cgra_sched_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push_valid_i),
        .data_i      (push_ent),
        .pop_i       (zero_pop || ack_pop),
        .flush_i     (flush_i),
        .keep_head_i (state_q == ST_REQ),
        .data_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (queue_level_o)
    );

    assign push_ready_o = !full;
    assign acc_req_o    = req_q;
    assign ker_id_req_o = ker_q;
    assign col_busy_o   = busy_q;
    assign evt_o        = evt_q;

    assign idle_head = (state_q == ST_IDLE) && !empty;
    assign blocked   = |(head.col_mask & busy_q) || |pend_q[head.slot];
    assign zero_pop  = idle_head && (head.col_mask == '0) && !flush_i;
    assign go_req    = idle_head && (head.col_mask != '0) && !blocked
                       && !flush_i;
    assign ack_pop   = (state_q == ST_REQ) && acc_ack_i;
    assign stall_ev  = idle_head && (head.col_mask != '0) && blocked;

    // Completion clears land before the dispatch sets of the same cycle.
    always_comb begin
        busy_n = (busy_q & ~acc_end_i) | (ack_pop ? req_q : '0);
        evt_n  = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            pend_n[s] = pend_q[s] & ~acc_end_i;
            evt_n[s]  = (|pend_q[s] && pend_n[s] == '0)
                        || (zero_pop && head.slot == SW'(s));
            if (ack_pop && slot_q == SW'(s)) pend_n[s] = pend_n[s] | req_q;
        end
    end

    // Dispatch FSM with registered request outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            ker_q   <= '0;
            slot_q  <= '0;
        end else if (go_req) begin
            state_q <= ST_REQ;
            req_q   <= head.col_mask;
            ker_q   <= head.ker_id;
            slot_q  <= head.slot;
        end else if (ack_pop) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            ker_q   <= '0;
        end
    end

    // Column busy, per-slot pending masks and completion pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            evt_q  <= '0;
            for (int s = 0; s < N_SLOTS; s++) pend_q[s] <= '0;
        end else begin
            busy_q <= busy_n;
            evt_q  <= evt_n;
            for (int s = 0; s < N_SLOTS; s++) pend_q[s] <= pend_n[s];
        end
    end

`ifdef CGRA_SCHED_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of cycles the head waits on busy columns or slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_q <= '0;
        else if (stall_ev && stall_q != '1) stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt_o = stall_q;
`else
    logic unused_stall;
    assign unused_stall = stall_ev;
    assign stall_cnt_o  = '0;
`endif

endmodule
